// File: rtl/video_burst_responder.sv
//------------------------------------------------------------------------------
// Module      : video_burst_responder
// Description : Two-port video burst arbiter; fetches one 64-bit block per
//               burst and streams it back as four wrapped 16-bit words.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module video_burst_responder #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_as,
  input  logic        req1_as,
  input  logic [21:0] req0_address,
  input  logic [21:0] req1_address,
  output logic [15:0] rsp0_data,
  output logic [15:0] rsp1_data,
  output logic        rsp0_burstdata_valid,
  output logic        rsp1_burstdata_valid,
  output logic        rsp0_bus_ack,
  output logic        rsp1_bus_ack,
  output logic        mem_req,
  output logic [18:0] mem_addr,
  input  logic        mem_ready,
  input  logic [63:0] mem_rdata,
  input  logic        mem_rvalid
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    STREAM   = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_port;
  logic        r_last;
  logic [1:0]  r_off;
  logic [1:0]  r_cnt;
  logic        r_done;
  logic [63:0] r_block;

  logic        w_grant_valid;
  logic        w_grant_port;
  logic [21:0] w_grant_addr;
  logic [1:0]  w_idx;
  logic        w_emit;
  logic        w_emit_last;
  logic [15:0] w_word;
  logic        w_unused;

  // Byte-address bit 0 carries no information for 16-bit words.
  assign w_unused = &{1'b0, req0_address[0], req1_address[0]};

  function automatic logic [15:0] f_pick(input logic [63:0] blk, input logic [1:0] idx);
    logic [15:0] v;
    case (idx)
      2'd0:    v = blk[63:48];
      2'd1:    v = blk[47:32];
      2'd2:    v = blk[31:16];
      default: v = blk[15:0];
    endcase
    return v;
  endfunction

  // Tie-break: port 1 only wins a tie when round-robin is on and port 0 went last.
  always_comb begin
    w_grant_valid = req0_as | req1_as;
    if (req0_as && req1_as) begin
      w_grant_port = (ROUND_ROBIN != 0) ? ~r_last : 1'b0;
    end else begin
      w_grant_port = req1_as;
    end
    w_grant_addr = w_grant_port ? req1_address : req0_address;
  end

  assign w_idx = r_off + r_cnt;

  always_comb begin
    w_emit      = 1'b0;
    w_emit_last = 1'b0;
    w_word      = 16'h0000;
    if (r_state == MEM_WAIT && mem_rvalid) begin
      w_emit = 1'b1;
      w_word = f_pick(mem_rdata, r_off);
    end else if (r_state == STREAM && !r_done) begin
      w_emit      = 1'b1;
      w_word      = f_pick(r_block, w_idx);
      w_emit_last = (r_cnt == 2'd3);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state              <= IDLE;
      r_port               <= 1'b0;
      r_last               <= 1'b1;
      r_off                <= 2'd0;
      r_cnt                <= 2'd0;
      r_done               <= 1'b0;
      r_block              <= 64'd0;
      mem_req              <= 1'b0;
      mem_addr             <= 19'd0;
      rsp0_data            <= 16'd0;
      rsp1_data            <= 16'd0;
      rsp0_burstdata_valid <= 1'b0;
      rsp1_burstdata_valid <= 1'b0;
      rsp0_bus_ack         <= 1'b0;
      rsp1_bus_ack         <= 1'b0;
    end else begin
      rsp0_burstdata_valid <= w_emit & ~r_port;
      rsp1_burstdata_valid <= w_emit & r_port;
      rsp0_data            <= (w_emit && !r_port) ? w_word : 16'd0;
      rsp1_data            <= (w_emit && r_port) ? w_word : 16'd0;
      rsp0_bus_ack         <= w_emit_last & ~r_port;
      rsp1_bus_ack         <= w_emit_last & r_port;
      r_done               <= w_emit_last;

      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_port   <= w_grant_port;
            r_last   <= w_grant_port;
            r_off    <= w_grant_addr[2:1];
            mem_req  <= 1'b1;
            mem_addr <= w_grant_addr[21:3];
            r_state  <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            r_state <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          // Word 0 goes out straight from mem_rdata; the rest come from r_block.
          if (mem_rvalid) begin
            r_block <= mem_rdata;
            r_cnt   <= 2'd1;
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (r_done) begin
            r_cnt   <= 2'd0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_video_burst_responder.sv
//------------------------------------------------------------------------------
// Module      : tb_video_burst_responder
// Description : Directed bench for video_burst_responder, both arbitration modes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_video_burst_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        as0, as1;
  logic [21:0] a0, a1;
  logic        mem_ready, mem_rvalid;
  logic [63:0] mem_rdata;

  logic [1:0][1:0][15:0] o_data;
  logic [1:0][1:0]       o_valid;
  logic [1:0][1:0]       o_ack;
  logic [1:0]            o_mreq;
  logic [1:0][18:0]      o_maddr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  video_burst_responder #(.ROUND_ROBIN(1)) u_rr1 (
    .clk(clk), .reset(reset),
    .req0_as(as0), .req1_as(as1), .req0_address(a0), .req1_address(a1),
    .rsp0_data(o_data[0][0]), .rsp1_data(o_data[0][1]),
    .rsp0_burstdata_valid(o_valid[0][0]), .rsp1_burstdata_valid(o_valid[0][1]),
    .rsp0_bus_ack(o_ack[0][0]), .rsp1_bus_ack(o_ack[0][1]),
    .mem_req(o_mreq[0]), .mem_addr(o_maddr[0]), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  video_burst_responder #(.ROUND_ROBIN(0)) u_rr0 (
    .clk(clk), .reset(reset),
    .req0_as(as0), .req1_as(as1), .req0_address(a0), .req1_address(a1),
    .rsp0_data(o_data[1][0]), .rsp1_data(o_data[1][1]),
    .rsp0_burstdata_valid(o_valid[1][0]), .rsp1_burstdata_valid(o_valid[1][1]),
    .rsp0_bus_ack(o_ack[1][0]), .rsp1_bus_ack(o_ack[1][1]),
    .mem_req(o_mreq[1]), .mem_addr(o_maddr[1]), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag, input int inst);
    chk({tag, "_p0"}, {o_valid[inst][0], o_ack[inst][0], o_data[inst][0]}, 64'd0);
    chk({tag, "_p1"}, {o_valid[inst][1], o_ack[inst][1], o_data[inst][1]}, 64'd0);
  endtask

  // Entered in a cycle where the DUT is IDLE; returns in the IDLE cycle after ack.
  task automatic burst(input int inst, input int port, input logic [21:0] addr,
                       input logic [18:0] exp_ma, input logic [63:0] data,
                       input logic [63:0] exp_w, input int rdly, input bit hold);
    int other;
    other = 1 - port;
    if (port == 0) begin as0 = 1'b1; a0 = addr; end
    else           begin as1 = 1'b1; a1 = addr; end
    tick();
    chk("mem_req_set", o_mreq[inst], 1);
    chk("mem_addr", o_maddr[inst], exp_ma);
    if (!hold) begin
      if (port == 0) begin as0 = 1'b0; a0 = 22'h3FFFFE; end
      else           begin as1 = 1'b0; a1 = 22'h3FFFFE; end
    end
    mem_ready = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      tick();
      chk("mem_req_hold", o_mreq[inst], 1);
      chk("mem_addr_hold", o_maddr[inst], exp_ma);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("mem_req_drop", o_mreq[inst], 0);
    chk("early_valid", o_valid[inst][port], 0);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      chk("word", o_data[inst][port], exp_w[63-16*k -: 16]);
      chk("valid", o_valid[inst][port], 1);
      chk("ack", o_ack[inst][port], (k == 3) ? 64'd1 : 64'd0);
      chk("other_port", {o_valid[inst][other], o_ack[inst][other], o_data[inst][other]}, 64'd0);
      if (k < 3) tick();
    end
    tick();
    chk("post_ack_quiet", {o_valid[inst][port], o_ack[inst][port], o_data[inst][port]}, 64'd0);
    chk("post_ack_mem_req", o_mreq[inst], 0);
  endtask

  initial begin
    reset = 1'b1; as0 = 1'b0; as1 = 1'b0; a0 = '0; a1 = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_mem_req", o_mreq[i], 0);
      chk("rst_mem_addr", o_maddr[i], 0);
      chk_quiet("rst_rsp", i);
    end
    reset = 1'b0;
    tick();

    // Single-port bursts with different word offsets.
    burst(0, 0, 22'h000400, 19'h080, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 0, 1'b0);
    burst(0, 1, 22'h000404, 19'h080, 64'h1111_2222_3333_4444, 64'h3333_4444_1111_2222, 0, 1'b0);
    burst(0, 0, 22'h000406, 19'h080, 64'hAAAA_BBBB_CCCC_DDDD, 64'hDDDD_AAAA_BBBB_CCCC, 0, 1'b0);

    // Tie from reset, round-robin: port 0 then port 1.
    reset = 1'b1; tick(); reset = 1'b0;
    as0 = 1'b1; a0 = 22'h000400; as1 = 1'b1; a1 = 22'h000404;
    burst(0, 0, 22'h000400, 19'h080, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 0, 1'b1);
    burst(0, 1, 22'h000404, 19'h080, 64'h1111_2222_3333_4444, 64'h3333_4444_1111_2222, 0, 1'b0);
    as0 = 1'b0; as1 = 1'b0;
    tick();

    // Fixed priority: port 0 held high starves port 1.
    reset = 1'b1; tick(); reset = 1'b0;
    as0 = 1'b1; a0 = 22'h000400; as1 = 1'b1; a1 = 22'h000404;
    burst(1, 0, 22'h000400, 19'h080, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 0, 1'b1);
    burst(1, 0, 22'h000400, 19'h080, 64'h5555_6666_7777_8888, 64'h5555_6666_7777_8888, 0, 1'b1);
    as0 = 1'b0; as1 = 1'b0;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    tick();

    // Held request with backpressure, then new address in the cycle after ack.
    burst(0, 0, 22'h000408, 19'h081, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 3, 1'b1);
    burst(0, 0, 22'h000410, 19'h082, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, 0, 1'b0);
    tick();

    // Reset during STREAM after the 2nd word, then a stale rvalid.
    as1 = 1'b1; a1 = 22'h000404;
    tick();
    as1 = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
    tick();
    mem_rvalid = 1'b0;
    chk("abort_w0", o_data[0][1], 16'h3333);
    tick();
    chk("abort_w1", o_data[0][1], 16'h4444);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_quiet("abort_rst", 0);
    chk("abort_mem_req", o_mreq[0], 0);
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_quiet("stale_rvalid", 0);
      chk("stale_mem_req", o_mreq[0], 0);
    end
    burst(0, 0, 22'h000400, 19'h080, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
